// File: rtl/edge_event_tx_if.sv
// edge_event_tx_if: event strobe in, pulse level and status out.
// The master side drives the strobe; the slave side is the transmitter.
interface edge_event_tx_if #(
  parameter int PEND_W = 2
);
  logic              din;
  logic              dout;
  logic              busy;
  logic [PEND_W-1:0] pend_cnt;
  logic              overflow;

  modport master (
    output din,
    input  dout,
    input  busy,
    input  pend_cnt,
    input  overflow
  );

  modport slave (
    input  din,
    output dout,
    output busy,
    output pend_cnt,
    output overflow
  );
endinterface

// File: rtl/edge_event_tx.sv
// edge_event_tx: turns single-cycle event strobes into one fixed-width high
// pulse per event, each followed by a guaranteed low gap, so a downstream
// synchronous rising-edge detector sees exactly one rising edge per event.
// Events that arrive while a pulse is in flight wait in a saturating counter.
// Optional build macro EDGE_EVENT_TX_OVERFLOW_EN adds a sticky overflow flag
// that records dropped events; without it the overflow output is tied low.
module edge_event_tx #(
  parameter int HIGH_CYCLES = 2,
  parameter int LOW_CYCLES  = 1,
  parameter int PEND_W      = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  edge_event_tx_if.slave        bus
);

  localparam int CNT_MAX = (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]  HIGH_LOAD = CNT_W'(HIGH_CYCLES - 1);
  localparam logic [CNT_W-1:0]  LOW_LOAD  = CNT_W'(LOW_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [PEND_W-1:0] PEND_MAX  = {PEND_W{1'b1}};
  localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_nextState;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_nextCnt;
  logic [PEND_W-1:0] r_pendCnt;
  logic [PEND_W-1:0] w_nextPendCnt;
  logic              w_enqueue;
  logic              w_consume;
  logic              w_pendFull;

  // State, countdown and pending counter registers; reset aborts any pulse
  // and discards the queue.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_pendCnt <= '0;
    end else begin
      r_state   <= w_nextState;
      r_cnt     <= w_nextCnt;
      r_pendCnt <= w_nextPendCnt;
    end
  end

  // Next-state logic: decides when a pulse starts/ends and whether the
  // current strobe is queued or taken from the queue.
  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    w_enqueue   = 1'b0;
    w_consume   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.din) begin
          w_nextState = ST_HIGH;
          w_nextCnt   = HIGH_LOAD;
        end
      end
      ST_HIGH: begin
        w_enqueue = bus.din;
        if (r_cnt != '0) begin
          w_nextCnt = r_cnt - CNT_ONE;
        end else begin
          w_nextState = ST_GAP;
          w_nextCnt   = LOW_LOAD;
        end
      end
      ST_GAP: begin
        if (r_cnt != '0) begin
          w_nextCnt = r_cnt - CNT_ONE;
          w_enqueue = bus.din;
        end else if ((r_pendCnt != '0) || bus.din) begin
          w_nextState = ST_HIGH;
          w_nextCnt   = HIGH_LOAD;
          if (r_pendCnt != '0) begin
            w_consume = 1'b1;
            w_enqueue = bus.din;
          end
        end else begin
          w_nextState = ST_IDLE;
        end
      end
      default: begin
        w_nextState = ST_IDLE;
        w_nextCnt   = '0;
      end
    endcase
  end

  // Pending counter update: a simultaneous enqueue and consume cancel, so a
  // full queue never drops an event that could have been absorbed.
  always_comb begin
    w_pendFull    = (r_pendCnt == PEND_MAX);
    w_nextPendCnt = r_pendCnt;
    if (w_enqueue && !w_consume && !w_pendFull) begin
      w_nextPendCnt = r_pendCnt + PEND_ONE;
    end else if (w_consume && !w_enqueue) begin
      w_nextPendCnt = r_pendCnt - PEND_ONE;
    end
  end

`ifdef EDGE_EVENT_TX_OVERFLOW_EN
  logic r_overflow;
  logic w_drop;

  assign w_drop = w_enqueue && !w_consume && w_pendFull;

  // Sticky record of any dropped event; only reset clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end
  end

  assign bus.overflow = r_overflow;
`else
  assign bus.overflow = 1'b0;
`endif

  assign bus.dout     = (r_state == ST_HIGH);
  assign bus.busy     = (r_state != ST_IDLE);
  assign bus.pend_cnt = r_pendCnt;

endmodule

// File: tb/tb_edge_event_tx.sv
// tb_edge_event_tx: randomized and directed stimulus for edge_event_tx with a
// pulse-schedule reference model feeding a scoreboard queue, plus rising-edge
// loopback counting on three differently parameterized instances.
module tb_edge_event_tx;

  localparam int H1 = 2;
  localparam int L1 = 1;
  localparam int PW = 2;
  localparam int PMAX = (1 << PW) - 1;

  typedef struct {
    logic dout;
    logic busy;
    int   pend;
    logic ovf;
  } exp_t;

  logic clk;
  logic reset;

  edge_event_tx_if #(.PEND_W(PW)) bus1 ();
  edge_event_tx_if #(.PEND_W(PW)) bus2 ();
  edge_event_tx_if #(.PEND_W(PW)) bus3 ();

  edge_event_tx #(.HIGH_CYCLES(H1), .LOW_CYCLES(L1), .PEND_W(PW)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1.slave)
  );
  edge_event_tx #(.HIGH_CYCLES(3), .LOW_CYCLES(2), .PEND_W(PW)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2.slave)
  );
  edge_event_tx #(.HIGH_CYCLES(1), .LOW_CYCLES(3), .PEND_W(PW)) dut3 (
    .clk(clk), .reset(reset), .bus(bus3.slave)
  );

  int   nChecks = 0;
  int   nPass   = 0;
  exp_t sbQ[$];

  // Reference model: tracks when the most recent pulse started and how many
  // accepted events are still waiting for a slot.
  int   mCyc  = 0;
  int   mLast = -1000;
  int   mPend = 0;
  logic mOvf  = 1'b0;

  logic       lbEn = 1'b0;
  logic [2:0] prevD = 3'b000;
  int         rises[3] = '{0, 0, 0};
  logic [2:0] douts;

  assign douts = {bus3.dout, bus2.dout, bus1.dout};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    nChecks++;
    if (act == exp) nPass++;
    else $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
  endtask

  task automatic modelStep(input logic d, input logic r);
    int   nextCyc;
    logic slotFree;
    exp_t e;
    nextCyc = mCyc + 1;
    if (r) begin
      mLast = -1000;
      mPend = 0;
      mOvf  = 1'b0;
    end else begin
      slotFree = (nextCyc >= mLast + H1 + L1);
      if (slotFree && (mPend > 0 || d)) begin
        mLast = nextCyc;
        if (mPend > 0) begin
          mPend--;
          if (d) mPend++;
        end
      end else if (d) begin
        if (mPend == PMAX) mOvf = 1'b1;
        else mPend++;
      end
    end
    mCyc   = nextCyc;
    e.dout = (mCyc >= mLast) && (mCyc < mLast + H1);
    e.busy = (mCyc >= mLast) && (mCyc < mLast + H1 + L1);
    e.pend = mPend;
`ifdef EDGE_EVENT_TX_OVERFLOW_EN
    e.ovf  = mOvf;
`else
    e.ovf  = 1'b0;
`endif
    sbQ.push_back(e);
  endtask

  // Drives one cycle of din/reset, lets the edge happen, then queues the
  // expected outputs for the cycle just entered.
  task automatic applyStimulus(input logic d, input logic r);
    bus1.din = d;
    bus2.din = d;
    bus3.din = d;
    reset    = r;
    @(posedge clk);
    modelStep(d, r);
    #1;
  endtask

  // Monitor: every cycle the DUT presents outputs, compare against the
  // oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (sbQ.size() > 0) begin
      e = sbQ.pop_front();
      checkOutput("dout", int'(bus1.dout), int'(e.dout));
      checkOutput("busy", int'(bus1.busy), int'(e.busy));
      checkOutput("pend_cnt", int'(bus1.pend_cnt), e.pend);
      checkOutput("overflow", int'(bus1.overflow), int'(e.ovf));
    end
  end

  // Rising-edge detectors on every instance's dout for the loopback phase.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (lbEn && douts[i] && !prevD[i]) rises[i] <= rises[i] + 1;
    end
    prevD <= douts;
  end

  task automatic resetPhase();
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0);
  endtask

  initial begin
    int expDout[10] = '{1, 1, 0, 1, 1, 0, 1, 1, 0, 0};
    int expBusy[10] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    int expPend[10] = '{0, 1, 2, 1, 1, 1, 0, 0, 0, 0};
    int sent;
    int burst;
    int gap;

    bus1.din = 1'b0;
    bus2.din = 1'b0;
    bus3.din = 1'b0;
    reset    = 1'b1;

    // Reset held with din high.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0);
    checkOutput("reset_dout", int'(bus1.dout), 0);
    checkOutput("reset_busy", int'(bus1.busy), 0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0);

    // Single event.
    applyStimulus(1'b1, 1'b0);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0);

    // Burst of three with directed pattern checks.
    resetPhase();
    for (int i = 0; i < 10; i++) begin
      applyStimulus((i < 3) ? 1'b1 : 1'b0, 1'b0);
      checkOutput($sformatf("burst_dout%0d", i), int'(bus1.dout), expDout[i]);
      checkOutput($sformatf("burst_busy%0d", i), int'(bus1.busy), expBusy[i]);
      checkOutput($sformatf("burst_pend%0d", i), int'(bus1.pend_cnt), expPend[i]);
    end

    // Overflow: eight consecutive events, then drain.
    resetPhase();
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0);
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b0);
`ifdef EDGE_EVENT_TX_OVERFLOW_EN
    checkOutput("ovf_sticky", int'(bus1.overflow), 1);
`else
    checkOutput("ovf_tied", int'(bus1.overflow), 0);
`endif
    checkOutput("ovf_drained", int'(bus1.busy), 0);

    // Reset mid-pulse, then a fresh event.
    resetPhase();
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0);

    // Random stress including overflow and sporadic resets.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), ($urandom_range(0, 63) == 0));
    end

    // Loopback: 200 events in short bursts with gaps wide enough that no
    // instance ever overflows.
    resetPhase();
    lbEn = 1'b1;
    sent = 0;
    while (sent < 200) begin
      burst = $urandom_range(1, 3);
      if (burst > 200 - sent) burst = 200 - sent;
      for (int i = 0; i < burst; i++) applyStimulus(1'b1, 1'b0);
      sent += burst;
      gap = $urandom_range(25, 35);
      for (int i = 0; i < gap; i++) applyStimulus(1'b0, 1'b0);
    end
    for (int i = 0; i < 40; i++) applyStimulus(1'b0, 1'b0);
    @(negedge clk);
    #1;
    lbEn = 1'b0;
    checkOutput("loop_h2l1", rises[0], 200);
    checkOutput("loop_h3l2", rises[1], 200);
    checkOutput("loop_h1l3", rises[2], 200);
    checkOutput("loop_idle2", int'(bus2.busy), 0);
    checkOutput("loop_idle3", int'(bus3.busy), 0);
    checkOutput("loop_ovf2", int'(bus2.overflow), 0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
